// File: rtl/chunked_addsub_seq.sv
// Multi-cycle add/subtract unit: a WIDTH-bit operand pair is summed CHUNK bits per clock,
// with the inter-chunk carry held in a register. start/busy/done handshake.
module chunked_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, work, work_nxt;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_out, c_msb;
  logic             accept, last;
  int               base;

  // One chunk of the addition plus the merged working result for this edge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    base     = int'(idx) * CHUNK;
    a_ch     = op_a[base +: CHUNK];
    b_ch     = op_b[base +: CHUNK];
    {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
    // Carry into the chunk MSB recovered from the MSB sum bit.
    c_msb    = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    work_nxt = work;
    work_nxt[base +: CHUNK] = s_ch;
  end

  assign last   = (idx == IDX_W'(N - 1));
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~ci, so the inversion happens once at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      work  <= '0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? ~ci : ci;
      idx   <= '0;
    end else if (state == RUN) begin
      work  <= work_nxt;
      carry <= c_out;
      idx   <= idx + IDX_W'(1);
      if (last) begin
        sum <= work_nxt;
        co  <= c_out;
        ovf <= c_msb ^ c_out;
      end
    end
  end

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Directed bench for chunked_addsub_seq: a 32/8 instance for table vectors and handshake
// corner cases, and an 8/8 instance for the single-chunk case.
module tb_chunked_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, ci;
  logic [31:0] a, b;
  logic        busy, done, co, ovf;
  logic [31:0] sum;

  logic        start8, sub8, ci8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ovf8;
  logic [7:0]  sum8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunked_addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
  );

  chunked_addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8), .ovf(ovf8)
  );

  typedef struct {
    string       name;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller sits #1 after a rising edge. Returns cycles from accept edge to done (-1 on timeout)
  // and the number of sampled busy cycles before done.
  task automatic run32(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                       input logic cc, output int lat, output int busy_n);
    start = 1'b1; sub = s; a = aa; b = bb; ci = cc;
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    lat    = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  int lat, busy_n, done_seen;

  initial begin
    vecs[0] = '{"add_wrap",     1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{"add_ovf",      1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{"sub_neg",      1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{"sub_ovf",      1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4] = '{"add_ci",       1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0};
    vecs[5] = '{"sub_borrow",   1'b1, 32'h00000010, 32'h00000003, 1'b1, 32'h0000000C, 1'b1, 1'b0};
    vecs[6] = '{"add_zero_ci",  1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[7] = '{"sub_zero_bi",  1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[8] = '{"add_negovf",   1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  sum, 32'd0);
    check("rst_co",   32'(co), 32'd0);
    check("rst_ovf",  32'(ovf), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven arithmetic vectors, with a one-cycle idle gap between them.
    foreach (vecs[i]) begin
      run32(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].ci, lat, busy_n);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'd4);
      check({vecs[i].name, "_sum"}, sum, vecs[i].sum);
      check({vecs[i].name, "_co"},  32'(co), 32'(vecs[i].co));
      check({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].ovf));
      if (i == 0) check("busy_cycles", 32'(busy_n), 32'd4);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
    end

    // start held high during the whole op: extra starts ignored, DONE-cycle start accepted.
    start = 1'b1; sub = 1'b0; a = 32'd1; b = 32'd2; ci = 1'b0;
    @(posedge clk); #1;
    a = 32'h99; b = 32'h99;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("hold_start_lat", 32'(lat), 32'd4);
    check("hold_start_sum", sum, 32'd3);
    a = 32'd10; b = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b_lat", 32'(lat), 32'd4);
    check("b2b_sum", sum, 32'd30);
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum", sum, 32'd30);
    check("hold_idle_busy", 32'(busy), 32'd0);

    // Reset two edges into an operation aborts it with no done pulse.
    start = 1'b1; sub = 1'b0; a = 32'hFFFFFFFF; b = 32'd1; ci = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum",  sum, 32'd0);
    check("abort_co",   32'(co), 32'd0);
    check("abort_ovf",  32'(ovf), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run32(1'b0, 32'd3, 32'd4, 1'b0, lat, busy_n);
    check("after_abort_lat", 32'(lat), 32'd4);
    check("after_abort_sum", sum, 32'd7);

    // Single-chunk instance: registered adder with one-cycle latency.
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'hC8; b8 = 8'h64; ci8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    check("w8_lat", 32'(lat), 32'd1);
    check("w8_sum", 32'(sum8), 32'h2D);
    check("w8_co",  32'(co8), 32'd1);
    check("w8_ovf", 32'(ovf8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
